// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, flag bit positions, instruction fields and sequencer states.
package cpu_pkg;
    localparam logic [3:0] OP_JMP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_LSL = 4'h3;
    localparam logic [3:0] OP_LSR = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8, OP_ST  = 4'h9, OP_MOV = 4'hA, OP_BEQ = 4'hB;
    localparam logic [3:0] OP_BNE = 4'hC, OP_BLT = 4'hD, OP_BGT = 4'hE, OP_CMP = 4'hF;

    localparam int FLAG_C = 3, FLAG_N = 2, FLAG_V = 1, FLAG_Z = 0;

    localparam int OPC_HI = 15, OPC_LO = 12, RD_HI = 11, RD_LO = 8;
    localparam int RA_HI  = 7,  RA_LO  = 4,  RB_HI = 3,  RB_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK
    } state_t;

    function automatic logic sets_flags(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_XOR, OP_CMP};
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return op inside {OP_JMP, OP_BEQ, OP_BNE, OP_BLT, OP_BGT};
    endfunction

    // The ALU never sees a carry-in from the flag register.
    function automatic logic [3:0] flags_to_alu(input logic [3:0] f);
        flags_to_alu = f;
        flags_to_alu[FLAG_C] = 1'b0;
    endfunction
endpackage

// File: rtl/branch_cond.sv
// branch_cond: decides whether a branch opcode is taken for the given {C,N,V,Z} flags.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] flags,
    output logic       taken
);
    logic n, z, unused_cv;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign unused_cv = ^{flags[FLAG_C], flags[FLAG_V]};
    assign taken = opcode == OP_JMP
                || (opcode == OP_BEQ && z)
                || (opcode == OP_BNE && !z)
                || (opcode == OP_BLT && n && !z)
                || (opcode == OP_BGT && !n && !z);
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute/memory/writeback sequencer that owns
// the pc and flag register and drives the ALU, register file and memory port.
module alu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [3:0]  rf_ra,
    output logic [3:0]  rf_rb,
    input  logic [15:0] rf_da,
    input  logic [15:0] rf_db,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [15:0] rf_wd,
    output logic [3:0]  alu_func,
    output logic [15:0] alu_op0,
    output logic [15:0] alu_op1,
    output logic        alu_flag_en,
    output logic [3:0]  alu_flag_in,
    input  logic [15:0] alu_q,
    input  logic [3:0]  alu_flag_out,
    output logic [15:0] pc,
    output logic [3:0]  flags,
    output logic        busy
);
    state_t      state, after;
    logic [15:0] ir, opa, opb, res, br_pc;
    logic [3:0]  op, rd;
    logic        taken;

    assign op    = ir[OPC_HI:OPC_LO];
    assign rd    = ir[RD_HI:RD_LO];
    assign rf_ra = ir[RA_HI:RA_LO];
    assign rf_rb = op == OP_ST ? rd : ir[RB_HI:RB_LO];
    assign busy  = state != S_IDLE;
    assign after = run ? S_FETCH : S_IDLE;
    assign br_pc = taken ? opa : pc;

    branch_cond u_branch_cond (.opcode(op), .flags(flags), .taken(taken));

    // Outputs are loaded on the transition into the state that presents them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            flags       <= RESET_FLAGS;
            ir          <= '0;
            opa         <= '0;
            opb         <= '0;
            res         <= '0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_wdata   <= '0;
            rf_we       <= 1'b0;
            rf_wa       <= '0;
            rf_wd       <= '0;
            alu_func    <= '0;
            alu_op0     <= '0;
            alu_op1     <= '0;
            alu_flag_en <= 1'b0;
            alu_flag_in <= '0;
        end else begin
            rf_we       <= 1'b0;
            alu_flag_en <= 1'b0;
            case (state)
                S_IDLE: if (run) begin
                    state    <= S_FETCH;
                    mem_rd   <= 1'b1;
                    mem_addr <= pc;
                end
                S_FETCH: if (mem_ready) begin
                    ir       <= mem_rdata;
                    pc       <= pc + 16'd1;
                    mem_rd   <= 1'b0;
                    mem_addr <= '0;
                    state    <= S_DECODE;
                end
                S_DECODE: begin
                    opa         <= rf_da;
                    opb         <= rf_db;
                    alu_func    <= op;
                    alu_op0     <= rf_da;
                    alu_op1     <= op == OP_MOV ? '0 : rf_db;
                    alu_flag_en <= sets_flags(op);
                    alu_flag_in <= flags_to_alu(flags);
                    state       <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    res <= alu_q;
                    if (sets_flags(op)) flags <= alu_flag_out;
                    if (op == OP_LD || op == OP_ST) begin
                        state     <= S_MEMORY;
                        mem_addr  <= alu_q;
                        mem_rd    <= op == OP_LD;
                        mem_wr    <= op == OP_ST;
                        mem_wdata <= op == OP_ST ? opb : '0;
                    end else if (op == OP_CMP || is_branch(op)) begin
                        state    <= after;
                        pc       <= br_pc;
                        mem_rd   <= run;
                        mem_addr <= run ? br_pc : '0;
                    end else begin
                        state <= S_WRITEBACK;
                        rf_we <= 1'b1;
                        rf_wa <= rd;
                        rf_wd <= alu_q;
                    end
                end
                S_MEMORY: if (mem_ready) begin
                    mem_wr    <= 1'b0;
                    mem_wdata <= '0;
                    if (op == OP_LD) begin
                        res      <= mem_rdata;
                        mem_rd   <= 1'b0;
                        mem_addr <= '0;
                        rf_we    <= 1'b1;
                        rf_wa    <= rd;
                        rf_wd    <= mem_rdata;
                        state    <= S_WRITEBACK;
                    end else begin
                        mem_rd   <= run;
                        mem_addr <= run ? pc : '0;
                        state    <= after;
                    end
                end
                S_WRITEBACK: begin
                    mem_rd   <= run;
                    mem_addr <= run ? pc : '0;
                    state    <= after;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
